shift_add_mult_4: RTL

- Sequential 4x4 unsigned multiplier built on the team's 4-bit ripple-carry adder (rca_4) as its only arithmetic element.
- Sits directly downstream of the adder stage: captures two 4-bit operands on a START handshake and iterates shift-and-add for 4 cycles.
- Presents an 8-bit PRODUCT with a one-cycle DONE pulse.
- Next step in the lab datapath after combinational addition.

---
 rtl/shift_add_mult_4_pkg.sv | 17 +
 rtl/shift_add_mult_4_rca.sv | 21 ++
 rtl/shift_add_mult_4.sv | 72 +++++++
 3 files changed

// File: rtl/shift_add_mult_4_pkg.sv
// Shared constants for the sequential shift-and-add 4x4 multiplier:
// state encoding, iteration count and product width.
package shift_add_mult_4_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      CALC    = 2'b01,
      DONE_ST = 2'b10
   } state_t;

   localparam int N_ITER = 4;
   localparam int PROD_W = 8;

   // Counter value seen on the edge that performs the last iteration.
   localparam logic [1:0] CNT_LAST = 2'(N_ITER - 1);

endpackage

// File: rtl/shift_add_mult_4_rca.sv
// 4-bit ripple-carry adder (rca_4), the multiplier's only arithmetic element.
module rca_4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] cy;

   assign cy[0] = cin;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign sum[i]  = a[i] ^ b[i] ^ cy[i];
      assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
   end

   assign cout = cy[4];

endmodule

// File: rtl/shift_add_mult_4.sv
// Sequential 4x4 unsigned multiplier: captures A/B on START, runs four
// shift-and-add iterations through rca_4, then pulses DONE with PRODUCT.
module shift_add_mult_4
   import shift_add_mult_4_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [3:0]        A,
   input  logic [3:0]        B,
   output logic [PROD_W-1:0] PRODUCT,
   output logic              DONE,
   output logic              BUSY
);

   state_t     state;
   logic [3:0] m;
   logic [3:0] acc;
   logic [3:0] q;
   logic [1:0] cnt;
   logic [3:0] addend;
   logic [3:0] sum;
   logic       c;

   assign addend = q[0] ? m : 4'b0000;

   rca_4 u_rca (
      .a    (acc),
      .b    (addend),
      .cin  (1'b0),
      .sum  (sum),
      .cout (c)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         m       <= 4'b0000;
         acc     <= 4'b0000;
         q       <= 4'b0000;
         cnt     <= 2'b00;
         PRODUCT <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  m     <= A;
                  q     <= B;
                  acc   <= 4'b0000;
                  cnt   <= 2'b00;
                  state <= CALC;
               end
            end
            CALC: begin
               // The adder carry shifts into acc[3], so no product bit is lost.
               {acc, q} <= {c, sum, q[3:1]};
               cnt      <= cnt + 2'd1;
               if (cnt == CNT_LAST) begin
                  PRODUCT <= {c, sum, q[3:1]};
                  state   <= DONE_ST;
               end
            end
            DONE_ST: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign DONE = (state == DONE_ST);
   assign BUSY = (state == CALC) || (state == DONE_ST);

endmodule
